// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I MEM/WB stage with a req/ack data-memory port, load alignment and a register-file write port
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_alu_result,
    input  logic [31:0] i_ex_rs2_data,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_RegWrite,
    input  logic        i_ex_MemRead,
    input  logic        i_ex_MemWrite,
    input  logic [2:0]  i_ex_funct3,
    output logic        o_mem_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_writedata,
    output logic [4:0]  o_write_rd,
    output logic        o_wb_RegWrite,
    output logic        o_mem_misaligned,
    output logic        o_mem_fault
);
    typedef enum logic {IDLE, REQ} state_t;
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req, r_we, r_wb, r_mis, r_fault;
    logic [31:0]   r_addr, r_wdata, r_writedata;
    logic [3:0]    r_be;
    logic [4:0]    r_rd, r_write_rd;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic          w_memop, w_byte, w_half, w_mis, w_timeout;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_load;
    logic [7:0]    w_lb;
    logic [15:0]   w_lh;
    // Decode the EX slot: access size, misalignment, byte enables and lane-replicated store data
    always_comb begin
        w_memop = i_ex_valid & (i_ex_MemRead | i_ex_MemWrite);
        w_off   = i_ex_alu_result[1:0];
        w_byte  = i_ex_funct3[1:0] == 2'b00;
        w_half  = i_ex_funct3[1:0] == 2'b01;
        w_mis   = w_half ? w_off[0] : (!w_byte && w_off != 2'b00);
        w_be    = w_byte ? (4'b0001 << w_off) : w_half ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = w_byte ? {4{i_ex_rs2_data[7:0]}} : w_half ? {2{i_ex_rs2_data[15:0]}} : i_ex_rs2_data;
    end
    // Pick the addressed byte/half from the returned word and extend it according to the latched funct3
    always_comb begin
        w_lb   = i_dmem_rdata[{r_lane, 3'b000} +: 8];
        w_lh   = i_dmem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load = (r_funct3[1:0] == 2'b00) ? {{24{!r_funct3[2] & w_lb[7]}}, w_lb} :
                 (r_funct3[1:0] == 2'b01) ? {{16{!r_funct3[2] & w_lh[15]}}, w_lh} : i_dmem_rdata;
        w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == CW'(ACK_TIMEOUT - 1));
    end
    // Hold upstream while a request is pending; release in the ack cycle so EX advances on that edge
    always_comb begin
        o_mem_stall = rst_n & ((r_state == REQ) ? !i_dmem_ack : (w_memop & !w_mis));
    end
    // IDLE/REQ controller with registered memory port, writeback port and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_writedata <= '0;
            r_write_rd  <= '0;
            r_wb        <= 1'b0;
            r_mis       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_wb    <= 1'b0;
            r_mis   <= 1'b0;
            r_fault <= 1'b0;
            if (r_state == IDLE) begin
                if (i_ex_valid && !w_memop) begin
                    r_writedata <= i_ex_alu_result;
                    r_write_rd  <= i_ex_rd;
                    r_wb        <= i_ex_RegWrite && (i_ex_rd != 5'd0);
                end else if (w_memop && w_mis) begin
                    r_mis <= 1'b1;
                end else if (w_memop) begin
                    r_state  <= REQ;
                    r_cnt    <= '0;
                    r_req    <= 1'b1;
                    r_we     <= i_ex_MemWrite;
                    r_addr   <= {i_ex_alu_result[31:2], 2'b00};
                    r_be     <= w_be;
                    r_wdata  <= w_wdata;
                    r_rd     <= i_ex_rd;
                    r_funct3 <= i_ex_funct3;
                    r_lane   <= w_off;
                end
            end else if (i_dmem_ack) begin
                r_state <= IDLE;
                r_req   <= 1'b0;
                if (!r_we) begin
                    r_writedata <= w_load;
                    r_write_rd  <= r_rd;
                    r_wb        <= r_rd != 5'd0;
                end
            end else if (w_timeout) begin
                r_state <= IDLE;
                r_req   <= 1'b0;
                r_fault <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_dmem_req       = r_req;
    assign o_dmem_we        = r_we;
    assign o_dmem_addr      = r_addr;
    assign o_dmem_wdata     = r_wdata;
    assign o_dmem_be        = r_be;
    assign o_writedata      = r_writedata;
    assign o_write_rd       = r_write_rd;
    assign o_wb_RegWrite    = r_wb;
    assign o_mem_misaligned = r_mis;
    assign o_mem_fault      = r_fault;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized self-checking bench for mem_wb_stage against a byte-level reference model
module tb_mem_wb_stage;
    localparam int TO = 40;
    logic        clk, rst_n;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [31:0] ex_alu_result, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, writedata;
    logic [3:0]  dmem_be;
    logic [4:0]  write_rd;
    logic        wb_RegWrite, mem_misaligned, mem_fault;
    int          n_vec = 0;
    int          n_err = 0;

    mem_wb_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ex_valid(ex_valid), .i_ex_alu_result(ex_alu_result), .i_ex_rs2_data(ex_rs2_data),
        .i_ex_rd(ex_rd), .i_ex_RegWrite(ex_RegWrite), .i_ex_MemRead(ex_MemRead),
        .i_ex_MemWrite(ex_MemWrite), .i_ex_funct3(ex_funct3),
        .o_mem_stall(mem_stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
        .o_writedata(writedata), .o_write_rd(write_rd), .o_wb_RegWrite(wb_RegWrite),
        .o_mem_misaligned(mem_misaligned), .o_mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        int sz;
        logic [63:0] v, m;
        sz = size_of(f3);
        v  = {32'b0, w} >> (8 * off);
        m  = (64'd1 << (8 * sz)) - 64'd1;
        v  = v & m;
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] off, input int sz);
        logic [3:0] be;
        for (int k = 0; k < 4; k++) be[k] = (k >= int'(off)) && (k < int'(off) + sz);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input int sz);
        logic [31:0] wd;
        for (int k = 0; k < 4; k++) wd[8*k+:8] = rs2[8*(k%sz)+:8];
        return wd;
    endfunction

    task automatic clear_ex;
        ex_valid = 0; ex_MemRead = 0; ex_MemWrite = 0; ex_RegWrite = 0;
    endtask

    // One memory instruction from issue to writeback, with waits of dly cycles before ack
    task automatic mem_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd, input int dly,
                           input logic [31:0] rdata);
        int sz;
        bit mis;
        logic [31:0] exp_wd;
        sz  = size_of(f3);
        mis = (int'(addr[1:0]) % sz) != 0;
        ex_valid = 1; ex_MemRead = !st; ex_MemWrite = st; ex_RegWrite = !st;
        ex_funct3 = f3; ex_alu_result = addr; ex_rs2_data = rs2; ex_rd = rd;
        #1;
        n_vec++;
        if (mem_stall !== !mis) begin
            n_err++; $display("FAIL issue_stall addr=%h f3=%0d got %b want %b", addr, f3, mem_stall, !mis);
        end
        step();
        if (mis) begin
            n_vec++;
            if ({mem_misaligned, dmem_req, wb_RegWrite} !== 3'b100) begin
                n_err++; $display("FAIL misaligned addr=%h f3=%0d got mis/req/wb=%b want 100", addr, f3,
                                  {mem_misaligned, dmem_req, wb_RegWrite});
            end
            clear_ex();
            step();
            n_vec++;
            if (mem_misaligned !== 1'b0) begin
                n_err++; $display("FAIL misaligned_pulse got %b want 0", mem_misaligned);
            end
            return;
        end
        exp_wd = ref_wdata(rs2, sz);
        n_vec++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_RegWrite} !==
            {1'b1, st, addr & 32'hFFFF_FFFC, ref_be(addr[1:0], sz), exp_wd, 1'b0}) begin
            n_err++;
            $display("FAIL req_fields addr=%h f3=%0d got req=%b we=%b a=%h be=%b wd=%h wb=%b want 1 %b %h %b %h 0",
                     addr, f3, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_RegWrite,
                     st, addr & 32'hFFFF_FFFC, ref_be(addr[1:0], sz), exp_wd);
        end
        for (int i = 0; i < dly; i++) begin
            #1;
            n_vec++;
            if ({mem_stall, dmem_req} !== 2'b11) begin
                n_err++; $display("FAIL wait_stall cycle %0d got stall/req=%b want 11", i, {mem_stall, dmem_req});
            end
            step();
        end
        dmem_ack = 1; dmem_rdata = rdata;
        #1;
        n_vec++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL ack_stall got %b want 0", mem_stall);
        end
        step();
        dmem_ack = 0;
        clear_ex();
        n_vec++;
        if ({dmem_req, wb_RegWrite} !== {1'b0, !st && rd != 0}) begin
            n_err++; $display("FAIL ack_wb st=%b rd=%0d got req/wb=%b want %b", st, rd,
                              {dmem_req, wb_RegWrite}, {1'b0, !st && rd != 0});
        end
        if (!st) begin
            n_vec++;
            if ({writedata, write_rd} !== {ref_load(rdata, addr[1:0], f3), rd}) begin
                n_err++; $display("FAIL load_data addr=%h f3=%0d rdata=%h got %h/%0d want %h/%0d", addr, f3,
                                  rdata, writedata, write_rd, ref_load(rdata, addr[1:0], f3), rd);
            end
        end
        step();
        n_vec++;
        if (wb_RegWrite !== 1'b0) begin
            n_err++; $display("FAIL wb_pulse got %b want 0", wb_RegWrite);
        end
    endtask

    task automatic test_reset;
        rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
        ex_valid = 1; ex_MemRead = 1; ex_MemWrite = 0; ex_RegWrite = 1;
        ex_funct3 = 3'b010; ex_alu_result = 32'h100; ex_rs2_data = 0; ex_rd = 3;
        step();
        step();
        n_vec++;
        if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, writedata, write_rd,
             wb_RegWrite, mem_misaligned, mem_fault} !== '0) begin
            n_err++; $display("FAIL reset_state got req=%b we=%b a=%h wd=%h be=%b d=%h rd=%0d stall=%b want all 0",
                              dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, writedata, write_rd, mem_stall);
        end
        clear_ex();
        rst_n = 1;
        step();
    endtask

    task automatic test_alu;
        ex_valid = 1; ex_RegWrite = 1; ex_MemRead = 0; ex_MemWrite = 0;
        ex_rd = 5; ex_alu_result = 32'h0000_1234; ex_funct3 = 0;
        #1;
        n_vec++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL alu_stall got %b want 0", mem_stall);
        end
        step();
        clear_ex();
        n_vec++;
        if ({wb_RegWrite, write_rd, writedata} !== {1'b1, 5'd5, 32'h1234}) begin
            n_err++; $display("FAIL alu_wb got %b/%0d/%h want 1/5/00001234", wb_RegWrite, write_rd, writedata);
        end
        step();
        n_vec++;
        if (wb_RegWrite !== 1'b0) begin
            n_err++; $display("FAIL alu_pulse got %b want 0", wb_RegWrite);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [4:0]  r;
        logic        w;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; r = 5'($urandom_range(0, 31)); w = 1'($urandom_range(0, 1));
            if (i == 0) r = 0;
            ex_valid = 1; ex_RegWrite = w; ex_rd = r; ex_alu_result = a;
            step();
            n_vec++;
            if ({wb_RegWrite, write_rd, writedata} !== {w && r != 0, r, a}) begin
                n_err++; $display("FAIL b2b_alu %0d got %b/%0d/%h want %b/%0d/%h", i, wb_RegWrite, write_rd,
                                  writedata, w && r != 0, r, a);
            end
        end
        clear_ex();
        step();
    endtask

    task automatic test_directed_mem;
        mem_txn(0, 3'b000, 32'h103, 0, 5'd9, 3, 32'h80FF_0000);
        mem_txn(0, 3'b100, 32'h103, 0, 5'd9, 3, 32'h80FF_0000);
        mem_txn(0, 3'b101, 32'h102, 0, 5'd10, 1, 32'h8001_0000);
        mem_txn(1, 3'b001, 32'h102, 32'h1234_ABCD, 5'd0, 2, 32'h0);
        mem_txn(0, 3'b010, 32'h101, 0, 5'd4, 0, 32'h0);
        mem_txn(0, 3'b010, 32'h104, 0, 5'd0, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_random_mem;
        for (int i = 0; i < 40; i++)
            mem_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom);
    endtask

    task automatic test_spurious_ack;
        logic [31:0] prev;
        prev = writedata;
        dmem_ack = 1; dmem_rdata = $urandom;
        step();
        dmem_ack = 0;
        n_vec++;
        if ({wb_RegWrite, dmem_req, writedata} !== {2'b00, prev}) begin
            n_err++; $display("FAIL spurious_ack got wb=%b req=%b d=%h want 0 0 %h", wb_RegWrite, dmem_req, writedata, prev);
        end
    endtask

    task automatic test_timeout;
        int n;
        ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_funct3 = 3'b010;
        ex_alu_result = 32'h200; ex_rd = 7;
        step();
        n = 0;
        while (dmem_req === 1'b1 && n < TO + 8) begin
            n++;
            step();
        end
        clear_ex();
        n_vec++;
        if ({n, mem_fault, wb_RegWrite, dmem_req} !== {TO, 3'b100}) begin
            n_err++; $display("FAIL timeout got cycles=%0d fault=%b wb=%b req=%b want %0d 1 0 0", n, mem_fault,
                              wb_RegWrite, dmem_req, TO);
        end
        #1;
        n_vec++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL timeout_stall got %b want 0", mem_stall);
        end
        step();
        n_vec++;
        if (mem_fault !== 1'b0) begin
            n_err++; $display("FAIL fault_pulse got %b want 0", mem_fault);
        end
    endtask

    task automatic test_reset_mid_req;
        ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_funct3 = 3'b010;
        ex_alu_result = 32'h300; ex_rd = 8;
        step();
        step();
        rst_n = 0;
        clear_ex();
        #1;
        n_vec++;
        if ({dmem_req, mem_stall} !== 2'b10) begin
            n_err++; $display("FAIL rst_stall got req/stall=%b want 10", {dmem_req, mem_stall});
        end
        step();
        n_vec++;
        if (dmem_req !== 1'b0) begin
            n_err++; $display("FAIL rst_req got %b want 0", dmem_req);
        end
        rst_n = 1;
        step();
        dmem_ack = 1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 0;
        n_vec++;
        if ({wb_RegWrite, dmem_req} !== 2'b00) begin
            n_err++; $display("FAIL late_ack got wb/req=%b want 00", {wb_RegWrite, dmem_req});
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_directed_mem();
        test_random_mem();
        test_spurious_ack();
        test_timeout();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
